// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, op classes, immediate formats,
// ALU function codes and the registered decode entry.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ALU_OP is {funct7[5], funct3}; ADD doubles as the default for non-ALU classes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_LUI    = 3'd5,
        CLS_AUIPC  = 3'd6
    } op_class_e;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        op_class_e   op_class;
        logic [31:0] pc;
    } dec_entry_t;

    // OP-IMM keeps funct7[5] only for the shift-right pair (SRLI/SRAI)
    function automatic logic [3:0] alu_op_imm(input logic [31:0] instr);
        return (instr[14:12] == 3'b101) ? {instr[30], instr[14:12]}
                                        : {1'b0, instr[14:12]};
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; all formats sign-extend from bit 31.
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry output buffer with register scoreboard.
// Optional illegal-opcode trap is enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage
    import decode_pkg::*;
(
    input  logic        RST,
    input  logic        CLK_DC,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTR,
    input  logic [31:0] PC,
    output logic [4:0]  A1,
    output logic [4:0]  A2,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [4:0]  A3,
    output logic        WE_OUT,
    output logic [31:0] IMM,
    output logic [3:0]  ALU_OP,
    output logic [2:0]  OP_CLASS,
    output logic [31:0] PC_OUT,
    input  logic        WB_DONE,
    input  logic [4:0]  WB_RD,
    input  logic        FLUSH
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,output logic        ILLEGAL
`endif
);

    state_e      state, state_nxt;
    dec_entry_t  ent, dec;
    imm_fmt_e    fmt;
    logic [31:0] busy, busy_nxt;
    logic        use_rs1, use_rs2, dec_illegal, hazard, full;
    logic        xfer_in, xfer_out;
    logic [6:0]  opc;
    logic [4:0]  rd;

    assign opc = INSTR[6:0];
    assign rd  = INSTR[11:7];
    assign A1  = INSTR[19:15];
    assign A2  = INSTR[24:20];

    always_comb begin
        dec.op_class = CLS_ALU;
        dec.we       = 1'b1;
        dec.alu_op   = ALU_ADD;
        dec.rd       = rd;
        dec.pc       = PC;
        fmt          = FMT_I;
        use_rs1      = 1'b1;
        use_rs2      = 1'b0;
        dec_illegal  = 1'b0;
        case (opc)
            OPC_OP: begin
                fmt        = FMT_R;
                use_rs2    = 1'b1;
                dec.alu_op = {INSTR[30], INSTR[14:12]};
            end
            OPC_OPIMM:  dec.alu_op = alu_op_imm(INSTR);
            OPC_LOAD:   dec.op_class = CLS_LOAD;
            OPC_STORE: begin
                dec.op_class = CLS_STORE;
                fmt          = FMT_S;
                dec.we       = 1'b0;
                use_rs2      = 1'b1;
            end
            OPC_BRANCH: begin
                dec.op_class = CLS_BRANCH;
                fmt          = FMT_B;
                dec.we       = 1'b0;
                use_rs2      = 1'b1;
            end
            OPC_JAL: begin
                dec.op_class = CLS_JUMP;
                fmt          = FMT_J;
                use_rs1      = 1'b0;
            end
            OPC_JALR:   dec.op_class = CLS_JUMP;
            OPC_LUI: begin
                dec.op_class = CLS_LUI;
                fmt          = FMT_U;
                use_rs1      = 1'b0;
            end
            OPC_AUIPC: begin
                dec.op_class = CLS_AUIPC;
                fmt          = FMT_U;
                use_rs1      = 1'b0;
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                dec_illegal = 1'b1;
                dec.we      = 1'b0;
                use_rs1     = 1'b0;
`else
                dec.alu_op  = alu_op_imm(INSTR);
`endif
            end
        endcase
    end

    imm_gen u_imm_gen (
        .instr (INSTR[31:7]),
        .fmt   (fmt),
        .imm   (dec.imm)
    );

    // busy[0] is held at zero, so x0 operands never stall
    assign hazard   = (use_rs1 && busy[A1]) || (use_rs2 && busy[A2]);
    assign full     = (state == ST_FULL);
    assign IN_READY = (!full || OUT_READY) && !hazard && !FLUSH;
    assign xfer_in  = IN_VALID && IN_READY;
    assign xfer_out = full && OUT_READY;

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) state <= ST_EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (FLUSH)         state_nxt = ST_EMPTY;
        else if (xfer_in)  state_nxt = ST_FULL;
        else if (xfer_out) state_nxt = ST_EMPTY;
    end

    always_comb begin
        OUT_VALID = (state == ST_FULL);
    end

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST)         ent <= '0;
        else if (xfer_in) ent <= dec;
    end

    assign A3       = ent.rd;
    assign WE_OUT   = ent.we;
    assign IMM      = ent.imm;
    assign ALU_OP   = ent.alu_op;
    assign OP_CLASS = ent.op_class;
    assign PC_OUT   = ent.pc;

`ifdef DECODE_ILLEGAL_TRAP_EN
    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST)         ILLEGAL <= 1'b0;
        else if (xfer_in) ILLEGAL <= dec_illegal;
    end
`else
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
`endif

    // Clears first, then the set, so a same-cycle set on the same register wins
    always_comb begin
        busy_nxt = busy;
        if (WB_DONE)
            busy_nxt[WB_RD] = 1'b0;
        if (FLUSH && full && ent.we)
            busy_nxt[ent.rd] = 1'b0;
        if (xfer_in && dec.we)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) busy <= '0;
        else      busy <= busy_nxt;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; scoreboard state is observed
// through IN_READY using probe instructions that read the register of interest.
module tb_decode_stage;
    import decode_pkg::*;

    logic        RST, CLK_DC;
    logic        IN_VALID, IN_READY, OUT_VALID, OUT_READY;
    logic [31:0] INSTR, PC, IMM, PC_OUT;
    logic [4:0]  A1, A2, A3, WB_RD;
    logic        WE_OUT, WB_DONE, FLUSH;
    logic [3:0]  ALU_OP;
    logic [2:0]  OP_CLASS;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        ILLEGAL;
`endif

    int n_chk = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADDI_X5   = 32'h0070_0293; // addi x5,x0,7
    localparam logic [31:0] I_ADD_X6    = 32'h0012_8333; // add  x6,x5,x1
    localparam logic [31:0] I_LUI_X7    = 32'h1234_53B7; // lui  x7,0x12345
    localparam logic [31:0] I_SW        = 32'hFE51_2E23; // sw   x5,-4(x2)
    localparam logic [31:0] I_ADDI_X9   = 32'h001E_0493; // addi x9,x28,1
    localparam logic [31:0] I_JAL       = 32'h801F_F0EF; // jal  x1,-2048
    localparam logic [31:0] I_SRAI      = 32'h4034_D413; // srai x8,x9,3
    localparam logic [31:0] I_SUB       = 32'h40C5_8533; // sub  x10,x11,x12
    localparam logic [31:0] I_BEQ       = 32'hFE00_0CE3; // beq  x0,x0,-8
    localparam logic [31:0] I_CUSTOM    = 32'h0050_008B; // custom-0, I-shaped
    localparam logic [31:0] P_X5        = 32'h0002_8013; // addi x0,x5,0
    localparam logic [31:0] P_X5_X6     = 32'h0062_8033; // add  x0,x5,x6

    decode_stage dut (
        .RST       (RST),
        .CLK_DC    (CLK_DC),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .INSTR     (INSTR),
        .PC        (PC),
        .A1        (A1),
        .A2        (A2),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .A3        (A3),
        .WE_OUT    (WE_OUT),
        .IMM       (IMM),
        .ALU_OP    (ALU_OP),
        .OP_CLASS  (OP_CLASS),
        .PC_OUT    (PC_OUT),
        .WB_DONE   (WB_DONE),
        .WB_RD     (WB_RD),
        .FLUSH     (FLUSH)
`ifdef DECODE_ILLEGAL_TRAP_EN
       ,.ILLEGAL   (ILLEGAL)
`endif
    );

    initial CLK_DC = 1'b0;
    always #5 CLK_DC = ~CLK_DC;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
        @(negedge CLK_DC);
        IN_VALID  = v;
        INSTR     = ins;
        PC        = pc;
        OUT_READY = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK_DC);
        #1;
    endtask

    initial begin
        RST = 1'b0; IN_VALID = 1'b0; INSTR = '0; PC = '0; OUT_READY = 1'b0;
        WB_DONE = 1'b0; WB_RD = '0; FLUSH = 1'b0;
        #2;
        chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("rst_a3", {27'b0, A3}, 32'd0);
        chk("rst_imm", IMM, 32'd0);
        chk("rst_pc_out", PC_OUT, 32'd0);
        @(negedge CLK_DC);
        RST = 1'b1;

        // ADDI x5,x0,7 accepted; rs1 field decoded combinationally
        drive(1'b1, I_ADDI_X5, 32'h100, 1'b1);
        chk("addi_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("addi_a1", {27'b0, A1}, 32'd0);
        tick();
        chk("addi_out_valid", {31'b0, OUT_VALID}, 32'd1);
        chk("addi_a3", {27'b0, A3}, 32'd5);
        chk("addi_imm", IMM, 32'd7);
        chk("addi_we", {31'b0, WE_OUT}, 32'd1);
        chk("addi_class", {29'b0, OP_CLASS}, {29'b0, CLS_ALU});
        chk("addi_pc_out", PC_OUT, 32'h100);

        // ADD reading x5 stalls until writeback of x5 retires
        drive(1'b1, I_ADD_X6, 32'h104, 1'b1);
        chk("add_hazard", {31'b0, IN_READY}, 32'd0);
        chk("add_a2", {27'b0, A2}, 32'd1);
        WB_DONE = 1'b1; WB_RD = 5'd5;
        #1;
        chk("add_hazard_wb_cycle", {31'b0, IN_READY}, 32'd0);
        tick();
        WB_DONE = 1'b0;
        #1;
        chk("drain_empty", {31'b0, OUT_VALID}, 32'd0);
        chk("add_ready_after_wb", {31'b0, IN_READY}, 32'd1);
        tick();
        chk("add_a3", {27'b0, A3}, 32'd6);
        chk("add_imm_r", IMM, 32'd0);

        // Back-pressure: held entry stays put for three cycles
        drive(1'b1, I_LUI_X7, 32'h108, 1'b0);
        chk("bp_in_ready", {31'b0, IN_READY}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", {31'b0, OUT_VALID}, 32'd1);
            chk("bp_hold_a3", {27'b0, A3}, 32'd6);
            chk("bp_hold_pc", PC_OUT, 32'h104);
        end
        OUT_READY = 1'b1;
        tick();
        chk("lui_imm", IMM, 32'h1234_5000);
        chk("lui_class", {29'b0, OP_CLASS}, {29'b0, CLS_LUI});

        // Store: S-immediate, no write, no busy on the rd-field register (x28)
        drive(1'b1, I_SW, 32'h10C, 1'b1);
        tick();
        chk("sw_imm", IMM, 32'hFFFF_FFFC);
        chk("sw_we", {31'b0, WE_OUT}, 32'd0);
        chk("sw_class", {29'b0, OP_CLASS}, {29'b0, CLS_STORE});
        drive(1'b1, I_ADDI_X9, 32'h110, 1'b1);
        chk("sw_no_busy", {31'b0, IN_READY}, 32'd1);
        tick();

        drive(1'b1, I_JAL, 32'h114, 1'b1);
        tick();
        chk("jal_imm", IMM, 32'hFFFF_F800);
        chk("jal_class", {29'b0, OP_CLASS}, {29'b0, CLS_JUMP});
        chk("jal_we", {31'b0, WE_OUT}, 32'd1);

        // SRAI reads x9 (busy from addi x9) -> stall, then retire x9
        drive(1'b1, I_SRAI, 32'h118, 1'b1);
        chk("srai_hazard", {31'b0, IN_READY}, 32'd0);
        WB_DONE = 1'b1; WB_RD = 5'd9;
        tick();
        WB_DONE = 1'b0;
        tick();
        chk("srai_alu_op", {28'b0, ALU_OP}, {28'b0, ALU_SRA});
        chk("srai_imm", IMM, 32'h0000_0403);

        drive(1'b1, I_SUB, 32'h11C, 1'b1);
        tick();
        chk("sub_alu_op", {28'b0, ALU_OP}, {28'b0, ALU_SUB});

        drive(1'b1, I_BEQ, 32'h120, 1'b1);
        tick();
        chk("beq_imm", IMM, 32'hFFFF_FFF8);
        chk("beq_we", {31'b0, WE_OUT}, 32'd0);
        chk("beq_class", {29'b0, OP_CLASS}, {29'b0, CLS_BRANCH});

        drive(1'b1, I_CUSTOM, 32'h124, 1'b1);
        tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("custom_illegal", {31'b0, ILLEGAL}, 32'd1);
        chk("custom_we", {31'b0, WE_OUT}, 32'd0);
`else
        chk("custom_class", {29'b0, OP_CLASS}, {29'b0, CLS_ALU});
        chk("custom_imm", IMM, 32'd5);
        chk("custom_we", {31'b0, WE_OUT}, 32'd1);
`endif

        // Same-cycle retire of x5 and accept of ADDI x5: set wins
        drive(1'b1, I_ADDI_X5, 32'h128, 1'b1);
        WB_DONE = 1'b1; WB_RD = 5'd5;
        tick();
        WB_DONE = 1'b0;
        drive(1'b0, P_X5, 32'h0, 1'b1);
        chk("set_wins_busy5", {31'b0, IN_READY}, 32'd0);
        OUT_READY = 1'b0;
        FLUSH = 1'b1;
        #1;
        chk("flush_blocks_in", {31'b0, IN_READY}, 32'd0);
        tick();
        FLUSH = 1'b0;
        #1;
        chk("flush_empty", {31'b0, OUT_VALID}, 32'd0);
        chk("flush_clears_busy5", {31'b0, IN_READY}, 32'd1);

        // FLUSH while EMPTY leaves registered outputs alone
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("flush_empty_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("flush_empty_a3", {27'b0, A3}, 32'd5);
        chk("flush_empty_pc", PC_OUT, 32'h128);

        // Re-fill with busy bits set, then asynchronous reset mid-cycle
        drive(1'b1, I_ADDI_X5, 32'h200, 1'b1);
        tick();
        drive(1'b1, I_ADD_X6, 32'h204, 1'b1);
        chk("pre_rst_hazard", {31'b0, IN_READY}, 32'd0);
        drive(1'b1, P_X5_X6, 32'h208, 1'b1);
        #1;
        RST = 1'b0;
        #1;
        chk("arst_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("arst_pc_out", PC_OUT, 32'd0);
        chk("arst_busy_clear", {31'b0, IN_READY}, 32'd1);
        tick();
        chk("rst_discards_xfer", {31'b0, OUT_VALID}, 32'd0);
        @(negedge CLK_DC);
        RST = 1'b1;
        tick();
        chk("first_accept_after_rst", {31'b0, OUT_VALID}, 32'd1);
        chk("first_accept_pc", PC_OUT, 32'h208);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have reset RST, asynchronous, active-low; clock CLK_DC.
REQ-002 The ports SHALL be, in order:
- RST  in  1  asynchronous active-low reset
- CLK_DC  in  1  decode clock
- IN_VALID  in  1  fetch offers INSTR/PC
- IN_READY  out  1  decode accepts this cycle
- INSTR  in  32  RV32I instruction word
- PC  in  32  instruction address
- A1  out  5  rs1 read address, combinational from INSTR
- A2  out  5  rs2 read address, combinational from INSTR
- OUT_VALID  out  1  decoded entry held for execute
- OUT_READY  in  1  execute consumes entry
- A3  out  5  registered rd
- WE_OUT  out  1  registered rd-write flag
- IMM  out  32  registered sign-extended immediate
- ALU_OP  out  4  registered ALU function code
- OP_CLASS  out  3  registered ALU/LOAD/STORE/BRANCH/JUMP/LUI/AUIPC
- PC_OUT  out  32  registered PC
- WB_DONE  in  1  one-cycle pulse, synchronous to CLK_DC, on writeback retire
- WB_RD  in  5  register retired by WB_DONE
- FLUSH  in  1  discard held entry
- ILLEGAL  out  1  registered illegal-opcode flag (only with DECODE_ILLEGAL_TRAP_EN)

Function
REQ-003 The block SHALL hold one output entry; state EMPTY (OUT_VALID=0) or FULL (OUT_VALID=1).
REQ-004 Transfer in: IN_VALID && IN_READY at a CLK_DC rising edge SHALL load the output registers and go FULL.
REQ-005 Transfer out: OUT_VALID && OUT_READY with no transfer in SHALL go EMPTY; with a transfer in, SHALL stay FULL holding the new entry.
REQ-006 IN_READY SHALL be (EMPTY || OUT_READY) && !hazard && !FLUSH.
REQ-007 Scoreboard busy[31:1] SHALL record registers with an outstanding write; busy[0] is constant 0.
REQ-008 hazard SHALL be 1 when INSTR uses rs1 and busy[rs1], or uses rs2 and busy[rs2]; x0 never hazards; U/J types use neither, I/load/JALR use rs1 only.
REQ-009 A transfer in with WE_OUT=1 and rd!=0 SHALL set busy[rd] at the same edge.
REQ-010 WB_DONE SHALL clear busy[WB_RD] at the next edge; if set and clear target the same register in one cycle, set SHALL win.
REQ-011 WE_OUT SHALL be 0 for STORE and BRANCH, 1 otherwise; rd=0 still gives WE_OUT=1 but no scoreboard set.
REQ-012 IMM SHALL follow RV32I I/S/B/U/J formats, sign-extended from instruction bit 31; B/J bit 0 is 0; U low 12 bits 0.
REQ-013 ALU_OP SHALL encode {funct7[5], funct3} for OP, {0, funct3} for OP-IMM except SRAI uses funct7[5], ADD (0000) for all other classes.
REQ-014 FLUSH SHALL force EMPTY at the next edge, clear busy[A3] of the held entry if it set one, and block transfer in that cycle; FLUSH while EMPTY SHALL change nothing.
REQ-015 Registered outputs SHALL hold their value while FULL and not transferring.

Reset
REQ-016 RST low SHALL immediately force EMPTY, busy to all zero, and A3, WE_OUT, IMM, ALU_OP, OP_CLASS, PC_OUT, ILLEGAL to 0.
REQ-017 Reset asserted mid-transfer SHALL discard the transfer; first acceptance is possible on the first edge after RST rises.

Configuration
REQ-018 With DECODE_ILLEGAL_TRAP_EN defined, an opcode outside RV32I base (excluding SYSTEM/FENCE) SHALL set ILLEGAL=1 with the entry, force WE_OUT=0 and set no busy bit.
REQ-019 Without DECODE_ILLEGAL_TRAP_EN, the ILLEGAL port SHALL not exist and unknown opcodes SHALL decode as OP-IMM.

Structure
REQ-020 A shared package decode_pkg SHALL hold opcode constants, the OP_CLASS enum and the ALU_OP encodings.
REQ-021 Immediate generation SHALL be a combinational sub-module imm_gen; the scoreboard stays in decode_stage.

Verification
REQ-022 Scenarios:
- ADDI x5,x0,7 with IN_VALID=1, OUT_READY=1 -> next edge OUT_VALID=1, A3=5, IMM=7, WE_OUT=1, busy[5]=1.
- ADD x6,x5,x1 following while busy[5]=1 -> IN_READY=0; WB_DONE with WB_RD=5 -> next cycle IN_READY=1.
- OUT_READY=0 while FULL with new IN_VALID -> IN_READY=0, outputs unchanged for 3 cycles.
- SW x5,-4(x2) -> IMM=32'hFFFFFFFC, WE_OUT=0, no busy set; JAL offset -2048 -> IMM=32'hFFFFF800.
- Same-cycle WB_DONE WB_RD=5 and accept of ADDI x5 -> busy[5] remains 1; FLUSH next -> busy[5]=0, OUT_VALID=0.
- RST low while FULL with busy bits set -> OUT_VALID=0, busy all zero without a clock edge.
